// File: rtl/seq_priority_encoder.sv
// ============================================================================
// Module   : seq_priority_encoder
// Purpose  : Captures an N-bit request vector and drains it one set-bit index
//            per output handshake, lowest index first by default.
// Options  : `ENC_MSB_FIRST_EN selects highest-index-first priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_priority_encoder #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         zero_err,
  output logic         busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  localparam logic [N-1:0] LSB_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [0:0]   state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic         zero_err_q, zero_err_d;

  logic [W-1:0] sel_idx;
  logic         single_bit;
  logic         in_hs;
  logic         out_hs;
  logic [N-1:0] clr_mask;

  // Priority select: the last match in the scan order wins.
  always_comb begin
    sel_idx = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      if (pend_q[i]) sel_idx = W'(i);
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i]) sel_idx = W'(i);
    end
`endif
  end

  assign single_bit = (pend_q != '0) && ((pend_q & (pend_q - LSB_ONE)) == '0);
  assign clr_mask   = LSB_ONE << sel_idx;
  assign in_hs      = in_valid && (state_q == IDLE);
  assign out_hs     = out_ready && (state_q == DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      zero_err_q <= zero_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    zero_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_hs) begin
          if (in_vec != '0) begin
            pend_d  = in_vec;
            state_d = DRAIN;
          end else begin
            zero_err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_hs) begin
          pend_d = pend_q & ~clr_mask;
          if (single_bit) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DRAIN);
    busy      = (state_q == DRAIN);
    out_idx   = sel_idx;
    out_last  = single_bit;
    zero_err  = zero_err_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_priority_encoder.sv
// ============================================================================
// Module   : tb_seq_priority_encoder
// Purpose  : Self-checking bench for seq_priority_encoder (N=8 and N=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_priority_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_last, zero_err, busy;
  logic [7:0] in_vec;
  logic [2:0] out_idx;

  logic       in_valid4, in_ready4, out_valid4, out_last4, zero_err4, busy4;
  logic [3:0] in_vec4;
  logic [1:0] out_idx4;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  seq_priority_encoder #(.N(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last), .zero_err(zero_err), .busy(busy)
  );

  seq_priority_encoder #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_vec(in_vec4), .out_valid(out_valid4), .out_ready(1'b1),
    .out_idx(out_idx4), .out_last(out_last4), .zero_err(zero_err4), .busy(busy4)
  );

  typedef struct {
    logic [7:0] vec;
    int         mode;       // 0: ready always, 1: random ready, 2: ready low 3 cycles
    int         exp_cnt;
    logic [2:0] first_lsb;
    logic [2:0] first_msb;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference order: list of set-bit indices in service order.
  task automatic build_q(input logic [7:0] v);
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
`ifdef ENC_MSB_FIRST_EN
        exp_q.push_front(i);
`else
        exp_q.push_back(i);
`endif
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [7:0] v);
    @(negedge clk);
    chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_vec   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_vec   = 8'($urandom);
  endtask

  task automatic drain(input logic [7:0] v, input int mode,
                       output int n_out, output logic [2:0] first);
    int cyc;
    build_q(v);
    n_out = 0;
    cyc   = 0;
    first = '0;
    while (exp_q.size() > 0 && cyc < 200) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc >= 3);
      endcase
      if (mode == 1 && exp_q.size() > 1) begin
        in_valid = 1'b1;
        in_vec   = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("drain_out_valid", {31'd0, out_valid}, 32'd1);
      chk("drain_out_idx", {29'd0, out_idx}, exp_q[0]);
      chk("drain_out_last", {31'd0, out_last}, {31'd0, exp_q.size() == 1});
      chk("drain_busy", {31'd0, busy}, 32'd1);
      chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
      if (cyc == 0) first = out_idx;
      if (out_ready) begin
        void'(exp_q.pop_front());
        n_out++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain_timeout: %0d indices still pending, expected 0", exp_q.size());
    end
    @(negedge clk);
    chk("bubble_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bubble_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic zero_vec;
    send(8'h00);
    @(negedge clk);
    chk("zero_err_pulse", {31'd0, zero_err}, 32'd1);
    chk("zero_out_valid", {31'd0, out_valid}, 32'd0);
    chk("zero_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_err_clear", {31'd0, zero_err}, 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t       tbl[6];
  int         n_out;
  logic [2:0] first;
  logic [7:0] v;

  initial begin
    tbl[0] = '{8'b1001_0100, 0, 3, 3'd2, 3'd7};
    tbl[1] = '{8'b0000_0110, 2, 2, 3'd1, 3'd2};
    tbl[2] = '{8'h01,        0, 1, 3'd0, 3'd0};
    tbl[3] = '{8'h80,        1, 1, 3'd7, 3'd7};
    tbl[4] = '{8'hFF,        1, 8, 3'd0, 3'd7};
    tbl[5] = '{8'hA5,        1, 4, 3'd0, 3'd7};

    rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    in_valid4 = 1'b0; in_vec4 = '0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_idx", {29'd0, out_idx}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_zero_err", {31'd0, zero_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Legacy one-hot on the 4-wide instance.
    for (int i = 0; i < 4; i++) begin
      in_valid4 = 1'b1;
      in_vec4   = 4'(1 << i);
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      in_vec4   = 4'hF;
      @(negedge clk);
      chk("n4_out_valid", {31'd0, out_valid4}, 32'd1);
      chk("n4_out_idx", {30'd0, out_idx4}, i);
      chk("n4_out_last", {31'd0, out_last4}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("n4_idle", {30'd0, in_ready4, out_valid4}, 32'd2);
      @(posedge clk); #1;
    end

    for (int t = 0; t < 6; t++) begin
      send(tbl[t].vec);
      drain(tbl[t].vec, tbl[t].mode, n_out, first);
      chk("tbl_count", n_out, tbl[t].exp_cnt);
`ifdef ENC_MSB_FIRST_EN
      chk("tbl_first", {29'd0, first}, {29'd0, tbl[t].first_msb});
`else
      chk("tbl_first", {29'd0, first}, {29'd0, tbl[t].first_lsb});
`endif
    end

    zero_vec();

    // Asynchronous reset in the middle of a drain.
    send(8'hFF);
    build_q(8'hFF);
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b1;
      @(negedge clk);
      chk("rst_mid_idx", {29'd0, out_idx}, exp_q[0]);
      void'(exp_q.pop_front());
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    send(8'h80);
    drain(8'h80, 0, n_out, first);
    chk("post_rst_first", {29'd0, first}, 32'd7);
    chk("post_rst_count", n_out, 32'd1);

    // Randomized traffic against the reference order.
    for (int r = 0; r < 30; r++) begin
      v = 8'($urandom);
      if ($urandom_range(0, 7) == 0) v = 8'h00;
      if (v == 8'h00) begin
        zero_vec();
      end else begin
        send(v);
        drain(v, 1, n_out, first);
        chk("rand_count", n_out, $countones(v));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
